// File: rtl/prim_reqack_pkg.sv
// Shared types and helpers for the REQ/ACK source-side adapter.
// The timeout counter width helper is used only when PRIM_REQACK_TIMEOUT_EN is defined.
package prim_reqack_pkg;

  typedef enum logic {
    ReqackIdle = 1'b0,
    ReqackReq  = 1'b1
  } reqack_src_state_e;

  // Bits needed to count 0..timeout_cycles inclusive.
  function automatic int unsigned timeout_cnt_w(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/prim_reqack_stage.sv
// One-entry valid/data register with load and clear; load wins over clear.
module prim_reqack_stage #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             vld_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end else if (clear_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = data_q;

endmodule

// File: rtl/prim_reqack_src_adapter.sv
// Source-domain initiator turning a valid/ready stream into REQ/ACK transfers, with one staging slot.
// Optional REQ-without-ACK watchdog enabled by defining PRIM_REQACK_TIMEOUT_EN.
module prim_reqack_src_adapter
  import prim_reqack_pkg::*;
#(
  parameter int unsigned Width         = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             src_req_o,
  input  logic             src_ack_i,
  output logic [Width-1:0] src_data_o,
  output logic             busy_o,
  output logic             spurious_ack_o,
  output logic             timeout_o
);

  reqack_src_state_e state_q, state_d;
  logic [Width-1:0]  hold_q, hold_d;
  logic              stg_vld_q;
  logic [Width-1:0]  stg_q;
  logic              stg_load, stg_clear;
  logic              spurious_q;

  prim_reqack_stage #(
    .Width (Width)
  ) u_stage (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (stg_load),
    .clear_i (stg_clear),
    .data_i  (in_data_i),
    .valid_o (stg_vld_q),
    .data_o  (stg_q)
  );

  // hold_q may only move when entering REQ or on a REQ&ACK cycle, so the
  // synchronizer always samples stable data while the request is open.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stg_load  = 1'b0;
    stg_clear = 1'b0;
    case (state_q)
      ReqackIdle: begin
        if (in_valid_i) begin
          hold_d  = in_data_i;
          state_d = ReqackReq;
        end
      end
      ReqackReq: begin
        if (src_ack_i) begin
          if (stg_vld_q) begin
            hold_d    = stg_q;
            stg_clear = 1'b1;
          end else if (in_valid_i) begin
            hold_d = in_data_i;
          end else begin
            state_d = ReqackIdle;
          end
        end else if (in_valid_i && !stg_vld_q) begin
          stg_load = 1'b1;
        end
      end
      default: state_d = ReqackIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ReqackIdle;
      hold_q     <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      spurious_q <= src_ack_i && (state_q == ReqackIdle);
    end
  end

  assign src_req_o      = (state_q == ReqackReq);
  assign src_data_o     = hold_q;
  assign in_ready_o     = !stg_vld_q;
  assign busy_o         = (state_q == ReqackReq) || stg_vld_q;
  assign spurious_ack_o = spurious_q;

`ifdef PRIM_REQACK_TIMEOUT_EN
  localparam int unsigned CntW = timeout_cnt_w(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // The flag only reports; REQ is never withdrawn by the watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q != ReqackReq) || src_ack_i) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (src_ack_i) begin
        timeout_q <= 1'b0;
      end else if (cnt_q == CntMax) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout_o = 1'b0;
`endif

endmodule
